fp_dot_arbiter: RTL

Shares one pipelined `fp_dot` unit (4-element IEEE-754 single-precision dot product) among up to `NUM_REQ` clients, such as the matrix-matrix multiplier, the matrix-vector transform and lighting.
- Each cycle it grants at most one requester with a round-robin arbiter.
- It drives the granted operands into the dot unit.
- It carries a requester tag alongside the unit's fixed pipeline.
- It returns each result to the requester that issued it, exactly `LATENCY` cycles later.

---
 rtl/gpu_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 60 ++++++
 rtl/fp_dot_arbiter.sv | 105 ++++++++++
 3 files changed

// File: rtl/gpu_pkg.sv
// Shared GPU datapath types and constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gpu_pkg;

    typedef logic [31:0] fp32_t;
    typedef fp32_t vec4_t [4];

    // Pipeline depth of the shared fp_dot unit; arbiters sized to it must agree.
    localparam int DOT_LATENCY = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched upward from ptr, modulo N.
// Latency: grant is combinational from req and ptr; ptr updates on the next edge.
// Backpressure: none; a requester that drops req simply loses its turn.
//
// Ports: clk, reset_n (async, active-low); req[N] pending requests;
//        advance moves ptr past the current winner; grant[N] one-hot;
//        grant_idx binary index of the winner (0 when nothing granted).
module rr_arbiter #(
    parameter int  N   = 4,
    localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [N-1:0]   req,
    input  logic           advance,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_idx
);

    logic [IDW-1:0] ptr;
    logic           found;
    int             idx;
    logic [IDW-1:0] sel;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        sel       = '0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            sel = IDW'(idx);
            if (!found && req[sel]) begin
                found      = 1'b1;
                grant[sel] = 1'b1;
                grant_idx  = sel;
            end
        end
        // Grant is combinational, so it has to be squashed explicitly while
        // reset is held or a requester could see a handshake during reset.
        if (!reset_n) begin
            grant     = '0;
            grant_idx = '0;
            found     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= (grant_idx == IDW'(N - 1)) ? '0 : grant_idx + IDW'(1);
        end
    end

endmodule

// File: rtl/fp_dot_arbiter.sv
// Shares one pipelined fp_dot unit among NUM_REQ requesters, returning results by tag.
// Latency: issue in cycle T -> resp_valid in cycle T+LATENCY; grant is same-cycle.
// Backpressure: req_ready is the grant; responses have none and must be taken when shown.
//
// Ports: clk, reset_n (async, active-low);
//        req_valid/req_ready/req_a/req_b  requester issue side (req_ready one-hot);
//        resp_valid (one-hot), resp_q     result return, resp_q shared by all;
//        dot_a0..3, dot_b0..3 / dot_q     operands to and result from the external fp_dot;
//        busy                             at least one operation in flight.
module fp_dot_arbiter
    import gpu_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    parameter int  LATENCY = DOT_LATENCY,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0][3:0][31:0] req_a,
    input  logic [NUM_REQ-1:0][3:0][31:0] req_b,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic [31:0]                   resp_q,
    output logic [31:0]                   dot_a0,
    output logic [31:0]                   dot_a1,
    output logic [31:0]                   dot_a2,
    output logic [31:0]                   dot_a3,
    output logic [31:0]                   dot_b0,
    output logic [31:0]                   dot_b1,
    output logic [31:0]                   dot_b2,
    output logic [31:0]                   dot_b3,
    input  logic [31:0]                   dot_q,
    output logic                          busy
);

    logic [NUM_REQ-1:0] grant;
    logic [IDW-1:0]     grant_idx;
    logic               grant_any;

    // Tag shift register mirroring the fp_dot pipeline; index LATENCY-1 retires.
    logic [LATENCY-1:0]          tag_vld;
    logic [LATENCY-1:0][IDW-1:0] tag_id;

    vec4_t op_a;
    vec4_t op_b;

    assign grant_any = |grant;
    assign req_ready = grant;

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req_valid),
        .advance   (grant_any),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Operands are not registered: the requester holds them until granted,
    // and fp_dot captures them on the grant edge.
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            op_a[j] = '0;
            op_b[j] = '0;
            if (grant_any) begin
                op_a[j] = req_a[grant_idx][j];
                op_b[j] = req_b[grant_idx][j];
            end
        end
    end

    assign dot_a0 = op_a[0];
    assign dot_a1 = op_a[1];
    assign dot_a2 = op_a[2];
    assign dot_a3 = op_a[3];
    assign dot_b0 = op_b[0];
    assign dot_b1 = op_b[1];
    assign dot_b2 = op_b[2];
    assign dot_b3 = op_b[3];

    // No stall path: fp_dot has no enable, so the tags shift every cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_vld <= '0;
            tag_id  <= '0;
        end else begin
            tag_vld <= {tag_vld[LATENCY-2:0], grant_any};
            tag_id  <= {tag_id[LATENCY-2:0], grant_idx};
        end
    end

    always_comb begin
        resp_valid = '0;
        if (tag_vld[LATENCY-1]) begin
            resp_valid[tag_id[LATENCY-1]] = 1'b1;
        end
    end

    assign resp_q = dot_q;
    assign busy   = |tag_vld;

endmodule
